// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state encoding and field helpers shared
// by the multi-cycle control unit and its opcode decoder.
package ctrl_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_BEQ   = 4'h3;
    localparam logic [3:0] OP_J     = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/ctrl_fsm_unit_decoder.sv
// ctrl_decoder: combinational opcode classifier feeding the control FSM.
// Unknown opcodes raise only is_illegal_o.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       regdest_o,
    output logic       alusrc_o,
    output logic       memtoreg_o,
    output logic       is_mem_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       is_illegal_o
);

    // Map each opcode onto its level controls and instruction class
    always_comb begin
        regdest_o    = 1'b0;
        alusrc_o     = 1'b0;
        memtoreg_o   = 1'b0;
        is_mem_o     = 1'b0;
        is_branch_o  = 1'b0;
        is_jump_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: regdest_o = 1'b1;
            OP_LW: begin
                alusrc_o   = 1'b1;
                memtoreg_o = 1'b1;
                is_mem_o   = 1'b1;
            end
            OP_SW: begin
                alusrc_o = 1'b1;
                is_mem_o = 1'b1;
            end
            OP_BEQ:  is_branch_o = 1'b1;
            OP_J:    is_jump_o   = 1'b1;
            OP_ADDI: alusrc_o    = 1'b1;
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm_unit.sv
// ctrl_fsm_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes (else NOP).
module ctrl_fsm_unit
    import ctrl_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              instr_valid,
    output logic              fetch_req,
    input  logic              zero,
    output logic [DATA_W-1:0] instruct_reg,
    output logic              regdest,
    output logic              alusrc,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              memread,
    output logic              memwrite,
    output logic              branch,
    output logic              jump,
    output logic              pc_en,
    output logic              timeout,
    output logic              illegal
);

    localparam logic [15:0] TO_LIM = 16'(FETCH_TIMEOUT);
    localparam bit          TO_ON  = (FETCH_TIMEOUT != 0);

    state_t            state_q;
    logic [DATA_W-1:0] instr_q;
    logic              fetch_req_q;
    logic              regdest_q;
    logic              alusrc_q;
    logic              memtoreg_q;
    logic              regwrite_q;
    logic              memread_q;
    logic              memwrite_q;
    logic              branch_q;
    logic              jump_q;
    logic              pc_en_q;
    logic              timeout_q;
    logic              illegal_q;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;

    logic [3:0] dec_op;
    logic       dec_regdest;
    logic       dec_alusrc;
    logic       dec_memtoreg;
    logic       dec_mem;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_illegal;
    logic       accept;
    logic       waiting;
    logic       to_hit;
    logic       trap_hit;
    logic       unused_zero;

    // Branch outcome is resolved in the data path, not here
    assign unused_zero = zero;

    // While fetching, classify the incoming word so levels land in DECODE
    assign dec_op = (state_q == S_FETCH) ? opcode_of(instr_in)
                                         : opcode_of(instr_q);

    ctrl_decoder u_dec (
        .opcode_i     (dec_op),
        .regdest_o    (dec_regdest),
        .alusrc_o     (dec_alusrc),
        .memtoreg_o   (dec_memtoreg),
        .is_mem_o     (dec_mem),
        .is_branch_o  (dec_branch),
        .is_jump_o    (dec_jump),
        .is_illegal_o (dec_illegal)
    );

    assign accept  = (state_q == S_FETCH) && fetch_req_q && instr_valid;
    assign waiting = (state_q == S_FETCH) && fetch_req_q && !instr_valid;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap_hit = dec_illegal;
`else
    assign trap_hit = 1'b0;
`endif

    // Fetch wait counter: runs only while a request is unanswered
    always_comb begin
        cnt_d  = '0;
        to_hit = 1'b0;
        if (waiting) begin
            cnt_d  = (cnt_q == TO_LIM) ? cnt_q : cnt_q + 16'd1;
            to_hit = TO_ON && ((cnt_q + 16'd1) == TO_LIM);
        end
    end

    // Control FSM; every output is registered for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            instr_q     <= '0;
            fetch_req_q <= 1'b0;
            regdest_q   <= 1'b0;
            alusrc_q    <= 1'b0;
            memtoreg_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            pc_en_q     <= 1'b0;
            timeout_q   <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
            pc_en_q    <= 1'b0;
            if (to_hit) begin
                timeout_q <= 1'b1;
            end
            unique case (state_q)
                S_FETCH: begin
                    fetch_req_q <= 1'b1;
                    if (accept) begin
                        instr_q     <= instr_in;
                        state_q     <= S_DECODE;
                        fetch_req_q <= 1'b0;
                        regdest_q   <= dec_regdest;
                        alusrc_q    <= dec_alusrc;
                        memtoreg_q  <= dec_memtoreg;
                    end
                end
                S_DECODE: begin
                    if (trap_hit) begin
                        state_q     <= S_HALT;
                        illegal_q   <= 1'b1;
                        fetch_req_q <= 1'b0;
                    end else begin
                        state_q  <= S_EXEC;
                        branch_q <= dec_branch;
                        jump_q   <= dec_jump;
                        pc_en_q  <= dec_branch | dec_jump | dec_illegal;
                    end
                end
                S_EXEC: begin
                    if (dec_mem) begin
                        state_q    <= S_MEM;
                        memread_q  <= memtoreg_q;
                        memwrite_q <= ~memtoreg_q;
                        pc_en_q    <= ~memtoreg_q;
                    end else if (dec_branch | dec_jump | dec_illegal) begin
                        state_q     <= S_FETCH;
                        fetch_req_q <= 1'b1;
                        regdest_q   <= 1'b0;
                        alusrc_q    <= 1'b0;
                        memtoreg_q  <= 1'b0;
                    end else begin
                        state_q    <= S_WB;
                        regwrite_q <= 1'b1;
                        pc_en_q    <= 1'b1;
                    end
                end
                S_MEM: begin
                    memread_q <= 1'b0;
                    if (memtoreg_q) begin
                        state_q    <= S_WB;
                        regwrite_q <= 1'b1;
                        pc_en_q    <= 1'b1;
                    end else begin
                        state_q     <= S_FETCH;
                        fetch_req_q <= 1'b1;
                        regdest_q   <= 1'b0;
                        alusrc_q    <= 1'b0;
                        memtoreg_q  <= 1'b0;
                    end
                end
                S_WB: begin
                    state_q     <= S_FETCH;
                    fetch_req_q <= 1'b1;
                    regdest_q   <= 1'b0;
                    alusrc_q    <= 1'b0;
                    memtoreg_q  <= 1'b0;
                end
                S_HALT: begin
                    fetch_req_q <= 1'b0;
                end
                default: begin
                    state_q     <= S_FETCH;
                    fetch_req_q <= 1'b1;
                end
            endcase
        end
    end

    assign fetch_req    = fetch_req_q;
    assign instruct_reg = instr_q;
    assign regdest      = regdest_q;
    assign alusrc       = alusrc_q;
    assign memtoreg     = memtoreg_q;
    assign regwrite     = regwrite_q;
    assign memread      = memread_q;
    assign memwrite     = memwrite_q;
    assign branch       = branch_q;
    assign jump         = jump_q;
    assign pc_en        = pc_en_q;
    assign timeout      = timeout_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_ctrl_fsm_unit.sv
// tb_ctrl_fsm_unit: directed and random stimulus for ctrl_fsm_unit,
// checked every cycle against a per-instruction schedule model.
module tb_ctrl_fsm_unit;

    localparam int TO = 255;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr_in = '0;
    logic        instr_valid = 1'b0;
    logic        zero = 1'b0;
    logic        fetch_req;
    logic [15:0] instruct_reg;
    logic        regdest, alusrc, memtoreg, regwrite;
    logic        memread, memwrite, branch, jump;
    logic        pc_en, timeout, illegal;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_fsm_unit #(.DATA_W(16), .FETCH_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .fetch_req    (fetch_req),
        .zero         (zero),
        .instruct_reg (instruct_reg),
        .regdest      (regdest),
        .alusrc       (alusrc),
        .memtoreg     (memtoreg),
        .regwrite     (regwrite),
        .memread      (memread),
        .memwrite     (memwrite),
        .branch       (branch),
        .jump         (jump),
        .pc_en        (pc_en),
        .timeout      (timeout),
        .illegal      (illegal)
    );

    // ---------------- reference model ----------------
    // m_k = cycles since acceptance (0 = fetching)
    int          m_k = 0;
    int          m_wait = 0;
    logic [15:0] m_cur = '0;
    bit          m_ready = 0, m_halt = 0, m_to = 0, m_ill = 0;

    function automatic int op_lat(input logic [3:0] op);
        case (op)
            4'h1:             return 4;
            4'h0, 4'h2, 4'h5: return 3;
            default:          return 2;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_k = 0; m_wait = 0; m_cur = '0;
            m_ready = 0; m_halt = 0; m_to = 0; m_ill = 0;
        end else if (m_halt) begin
            m_k = 0;
        end else if (m_k == 0) begin
            if (m_ready && instr_valid) begin
                m_cur = instr_in; m_k = 1; m_wait = 0;
            end else if (m_ready) begin
                if (m_wait < TO) m_wait++;
                if (TO != 0 && m_wait == TO) m_to = 1;
            end
            m_ready = 1;
        end else begin
            if (TRAP && m_cur[15:12] > 4'h5 && m_k == 1) begin
                m_halt = 1; m_ill = 1; m_k = 0;
            end else if (m_k == op_lat(m_cur[15:12])) begin
                m_k = 0;
            end else begin
                m_k++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]  op;
            int          lat;
            bit          a;
            logic [27:0] ev, av;
            op  = m_cur[15:12];
            lat = op_lat(op);
            a   = (m_k > 0);
            ev = {m_cur,
                  (!m_halt && m_k == 0 && m_ready),
                  (a && op == 4'h0),
                  (a && (op == 4'h1 || op == 4'h2 || op == 4'h5)),
                  (a && op == 4'h1),
                  (a && m_k == lat && (op == 4'h0 || op == 4'h1 || op == 4'h5)),
                  (m_k == 3 && op == 4'h1),
                  (m_k == 3 && op == 4'h2),
                  (m_k == 2 && op == 4'h3),
                  (m_k == 2 && op == 4'h4),
                  (a && m_k == lat),
                  m_to, m_ill};
            av = {instruct_reg, fetch_req, regdest, alusrc, memtoreg,
                  regwrite, memread, memwrite, branch, jump, pc_en,
                  timeout, illegal};
            n_checks++;
            if (av !== ev) begin
                n_errors++;
                $display("FAIL outputs t=%0t: got %h expected %h", $time, av, ev);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        instr_valid = 1'b0;
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!fetch_req && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("fetch_req_ready", 32'(fetch_req), 32'd1);
    endtask

    task automatic present(input logic [15:0] ins);
        wait_ready();
        instr_in = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_in = 16'($urandom);
    endtask

    task automatic run_instr(input logic [15:0] ins, input int e_lat,
                             input logic [2:0] e_lv, input int e_rw,
                             input int e_mr, input int e_mw,
                             input int e_br, input int e_jp);
        int lat = 0, rw = 0, mr = 0, mw = 0, br = 0, jp = 0;
        present(ins);
        check("decode_levels", 32'({regdest, alusrc, memtoreg}), 32'(e_lv));
        check("instruct_reg", 32'(instruct_reg), 32'(ins));
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (regwrite) rw++;
            if (memread)  mr++;
            if (memwrite) mw++;
            if (branch)   br++;
            if (jump)     jp++;
            if (pc_en) begin
                lat = cyc;
                break;
            end
            instr_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("retire_latency", 32'(lat), 32'(e_lat));
        check("strobe_counts", {rw[7:0], mr[3:0], mw[3:0], br[7:0], jp[7:0]},
              {8'(e_rw), 4'(e_mr), 4'(e_mw), 8'(e_br), 8'(e_jp)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, g, hcnt;
        logic [3:0] op;

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);

        do_reset(2);
        check("rst_outputs",
              32'({fetch_req, regdest, alusrc, memtoreg, regwrite, memread,
                   memwrite, branch, jump, pc_en, timeout, illegal}), 32'd0);
        check("rst_instruct_reg", 32'(instruct_reg), 32'd0);
        @(negedge clk);
        check("rst_fetch_req_next", 32'(fetch_req), 32'd1);

        run_instr(16'b0000100010000000, 3, 3'b100, 1, 0, 0, 0, 0);
        run_instr(16'h1285, 4, 3'b011, 1, 1, 0, 0, 0);
        run_instr(16'h2285, 3, 3'b010, 0, 0, 1, 0, 0);
        run_instr(16'h3283, 2, 3'b000, 0, 0, 0, 1, 0);
        run_instr(16'h4010, 2, 3'b000, 0, 0, 0, 0, 1);
        run_instr(16'h5A7F, 3, 3'b010, 1, 0, 0, 0, 0);

        // fetch timeout
        do_reset(1);
        n = 0;
        g = 0;
        while (!timeout && g < 400) begin
            if (fetch_req) n++;
            @(negedge clk);
            g++;
        end
        check("timeout_wait_cycles", 32'(n), 32'd255);
        while (g < 300) begin
            @(negedge clk);
            g++;
        end
        check("timeout_sticky", 32'(timeout), 32'd1);
        run_instr(16'h1285, 4, 3'b011, 1, 1, 0, 0, 0);
        check("timeout_after_instr", 32'(timeout), 32'd1);

        // reset in the middle of a load
        present(16'h1285);
        g = 0;
        while (!memread && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("memread_seen", 32'(memread), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_strobes",
              32'({memread, regwrite, pc_en, fetch_req, memtoreg}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_fetch_req", 32'(fetch_req), 32'd1);

        // illegal opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
        present(16'hF123);
        repeat (5) @(negedge clk);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_halted", 32'({fetch_req, pc_en}), 32'd0);
        do_reset(1);
        check("trap_cleared", 32'(illegal), 32'd0);
`else
        run_instr(16'hF123, 2, 3'b000, 0, 0, 0, 0, 0);
        check("nop_illegal_low", 32'(illegal), 32'd0);
`endif

        // random traffic
        hcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (m_halt) hcnt++;
            else hcnt = 0;
            if (reset) begin
                reset = 1'b0;
            end else if (hcnt > 4 || $urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                hcnt = 0;
            end
            instr_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(6, 15));
            else op = 4'($urandom_range(0, 5));
            instr_in = {op, 12'($urandom)};
        end
        reset = 1'b0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
